dm_arbiter: RTL

//  Shares the single data-memory port between the pipeline MEM stage (CPU) and an external master (debug/DMA loader).
//  CPU has fixed priority; a starvation counter forces an external slot after STARVE_MAX cycles of waiting.

---
 rtl/dm_arbiter_if.sv | 48 ++++
 rtl/dm_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// Bundle of CPU MEM-stage, external-master and data-memory signals around dm_arbiter.
// The slave side is the arbiter; the master side is the CPU/external master/memory environment.
interface dm_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [2:0]        cpu_op;
    logic [31:0]       cpu_pc;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [31:0]       ext_wdata;
    logic [2:0]        ext_op;
    logic              ext_ack;
    logic              ext_err;
    logic [31:0]       ext_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [2:0]        m_op;
    logic              m_we;
    logic [31:0]       m_pc;
    logic [31:0]       m_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_op, cpu_pc,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_op,
        input  m_rdata,
        output cpu_rdata, cpu_stall,
        output ext_ack, ext_err, ext_rdata,
        output m_addr, m_wdata, m_op, m_we, m_pc
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_op, cpu_pc,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_op,
        output m_rdata,
        input  cpu_rdata, cpu_stall,
        input  ext_ack, ext_err, ext_rdata,
        input  m_addr, m_wdata, m_op, m_we, m_pc
    );
endinterface

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: CPU has fixed priority, the external master gets a forced
// slot after STARVE_MAX cycles of waiting; external accesses complete with a one-cycle ack.
module dm_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [31:0] EXT_PC     = 32'hFFFF_FFFF,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave arb_if
);
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [OP_W-1:0]   OP_HALF    = OP_W'(1);
    localparam logic [OP_W-1:0]   OP_WORD    = OP_W'(2);
    localparam logic [OP_W-1:0]   OP_UHALF   = OP_W'(5);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = '0;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_ACK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             ext_ack_q, ext_ack_d;
    logic             ext_err_q, ext_err_d;
    logic [31:0]      ext_rdata_q, ext_rdata_d;

    logic ext_ok;
    logic ext_mis;
    logic force_ext;
    logic g_ext;
    logic g_cpu;

    function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] lsb);
        return ((op == OP_WORD) && (lsb != 2'b00)) ||
               (((op == OP_HALF) || (op == OP_UHALF)) && lsb[0]);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            starve_q    <= '0;
            ext_ack_q   <= 1'b0;
            ext_err_q   <= 1'b0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            ext_ack_q   <= ext_ack_d;
            ext_err_q   <= ext_err_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    // Grant decision, memory mux and next-state logic
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        ext_ack_d   = 1'b0;
        ext_err_d   = 1'b0;
        ext_rdata_d = ext_rdata_q;

        arb_if.m_addr  = ADDR_ZERO;
        arb_if.m_wdata = '0;
        arb_if.m_op    = '0;
        arb_if.m_we    = 1'b0;
        arb_if.m_pc    = '0;

        ext_ok    = arb_if.ext_req & (state_q == ST_ARB);
        ext_mis   = misaligned(arb_if.ext_op, arb_if.ext_addr[1:0]);
        force_ext = ext_ok & (starve_q == STARVE_LIM);
        g_ext     = ext_ok & (~arb_if.cpu_req | force_ext);
        g_cpu     = arb_if.cpu_req & ~g_ext;

        arb_if.cpu_stall = arb_if.cpu_req & g_ext;

        if (g_cpu) begin
            arb_if.m_addr  = arb_if.cpu_addr;
            arb_if.m_wdata = arb_if.cpu_wdata;
            arb_if.m_op    = arb_if.cpu_op;
            arb_if.m_we    = arb_if.cpu_we;
            arb_if.m_pc    = arb_if.cpu_pc;
        end else if (g_ext && !ext_mis) begin
            arb_if.m_addr  = arb_if.ext_addr;
            arb_if.m_wdata = arb_if.ext_wdata;
            arb_if.m_op    = arb_if.ext_op;
            arb_if.m_we    = arb_if.ext_we;
            arb_if.m_pc    = EXT_PC;
        end

        // A write landing in a reset cycle must not reach memory
        if (rst) begin
            arb_if.m_we = 1'b0;
        end

        if (g_ext) begin
            state_d     = ST_ACK;
            ext_ack_d   = 1'b1;
            ext_err_d   = ext_mis;
            ext_rdata_d = (arb_if.ext_we || ext_mis) ? 32'h0 : arb_if.m_rdata;
        end

        if (state_q == ST_ACK) begin
            state_d = ST_ARB;
        end

        // Waiting-time counter only moves in ARB; it is already zero on entry to ACK
        if (state_q == ST_ARB) begin
            if (g_ext || !arb_if.ext_req) begin
                starve_d = '0;
            end else if (g_cpu && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    assign arb_if.cpu_rdata = arb_if.m_rdata;
    assign arb_if.ext_ack   = ext_ack_q;
    assign arb_if.ext_err   = ext_err_q;
    assign arb_if.ext_rdata = ext_rdata_q;

endmodule
